// File: rtl/chunked_add_seq.sv
// Multi-cycle adder: one CHUNK-bit slice per cycle, LS chunk first, carry kept in a register.
// Operands in and result out through valid/ready handshakes.
module chunked_add_seq #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out,
   output logic             busy
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e            state_q;
   logic [WIDTH-1:0]  a_q, b_q, sum_q, sum_d;
   logic              carry_q, cout_q;
   logic [IDXW-1:0]   idx_q;

   logic [WIDTH-1:0]  a_sh, b_sh, mask, slice;
   logic [CHUNK:0]    add;
   int unsigned       base;

   // Shift the active chunk down to bit 0 rather than using a variable part-select,
   // so the NCHUNK == 1 case never forms an out-of-range select.
   always_comb begin
      base  = 32'(idx_q) * CHUNK;
      a_sh  = a_q >> base;
      b_sh  = b_q >> base;
      add   = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_q};
      mask  = WIDTH'({CHUNK{1'b1}}) << base;
      slice = WIDTH'(add[CHUNK-1:0]) << base;
      sum_d = (sum_q & ~mask) | slice;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         idx_q   <= '0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q     <= a;
               b_q     <= b;
               carry_q <= carry_in;
               sum_q   <= '0;
               idx_q   <= '0;
               state_q <= RUN;
            end
            RUN: begin
               sum_q   <= sum_d;
               carry_q <= add[CHUNK];
               if (idx_q == LAST) begin
                  cout_q  <= add[CHUNK];
                  idx_q   <= '0;
                  state_q <= DONE;
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign sum       = sum_q;
   assign carry_out = cout_q;
endmodule

// File: tb/tb_chunked_add_seq.sv
// Directed bench: 16/4 instance with a result scoreboard, plus an 8/8 degenerate instance.
module tb_chunked_add_seq;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
   logic [15:0] a, b, sum;
   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cin, b_cout, b_busy;
   logic [7:0]  b_a, b_b, b_sum;

   int          ncmp = 0;
   int          nfail = 0;
   int          nstep = 0;
   logic [16:0] sb[$];
   logic [8:0]  sbb[$];

   always #5 clk = ~clk;

   chunked_add_seq #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
      .carry_in(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
      .carry_out(cout), .busy(busy));

   chunked_add_seq #(.WIDTH(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .a(b_a), .b(b_b),
      .carry_in(b_cin), .out_valid(b_out_valid), .out_ready(b_out_ready), .sum(b_sum),
      .carry_out(b_cout), .busy(b_busy));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of the 16-bit DUT: record accepts and retire results before the edge.
   task automatic step(output bit acc);
      logic [16:0] e;
      acc = in_valid && in_ready;
      if (acc) sb.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
      if (out_valid && out_ready) begin
         if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("sum", {16'd0, sum}, {16'd0, e[15:0]});
            chk("carry_out", {31'd0, cout}, {31'd0, e[16]});
         end
      end
      @(posedge clk); #1;
      nstep++;
   endtask

   task automatic wait_valid(output int n);
      bit acc;
      n = 0;
      while (!out_valid && n < 50) begin step(acc); n++; end
      if (!out_valid) chk("out_valid_timeout", 32'd0, 32'd1);
   endtask

   task automatic accept(input logic [15:0] ia, input logic [15:0] ib, input logic ic);
      bit acc;
      a = ia; b = ib; cin = ic; in_valid = 1'b1;
      step(acc);
      chk("accepted", {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
   endtask

   initial begin
      int n, acc0, acc1, k, g;
      bit acc;
      logic [15:0] opa[2], opb[2];
      logic [8:0]  eb;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_a = '0; b_b = '0; b_cin = 1'b0;
      #12;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_sum", {16'd0, sum}, 32'd0);
      chk("rst_cout", {31'd0, cout}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic add with latency and single-cycle out_valid
      accept(16'h00FF, 16'h0001, 1'b0);
      chk("busy_run", {31'd0, busy}, 32'd1);
      wait_valid(n);
      chk("latency", n, 32'd4);
      step(acc);
      chk("ov_one_cycle", {31'd0, out_valid}, 32'd0);

      // Carry through every chunk
      accept(16'hFFFF, 16'h0000, 1'b1);
      wait_valid(n);
      step(acc);

      // Backpressure: result held, new operands ignored
      out_ready = 1'b0;
      accept(16'h1234, 16'h4321, 1'b0);
      wait_valid(n);
      a = 16'hAAAA; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step(acc);
         chk("bp_sum", {16'd0, sum}, 32'h5555);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      step(acc);
      chk("bp_release_idle", {31'd0, in_ready}, 32'd1);
      chk("bp_release_ov", {31'd0, out_valid}, 32'd0);
      step(acc);
      chk("bp_accept_after", {31'd0, acc}, 32'd1);
      in_valid = 1'b0;
      wait_valid(n);
      step(acc);

      // Reset during RUN after two chunks
      accept(16'hAAAA, 16'h5555, 1'b0);
      step(acc); step(acc);
      rst_n = 1'b0; #1;
      chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_sum", {16'd0, sum}, 32'd0);
      chk("mid_rst_cout", {31'd0, cout}, 32'd0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      accept(16'h0001, 16'h0001, 1'b0);
      wait_valid(n);
      step(acc);

      // Back-to-back throughput
      opa[0] = 16'h0001; opb[0] = 16'h0002;
      opa[1] = 16'hFFFF; opb[1] = 16'hFFFF;
      k = 0; g = 0; acc0 = 0; acc1 = 0; cin = 1'b0; in_valid = 1'b1;
      while (k < 2 && g < 40) begin
         a = opa[k]; b = opb[k];
         n = nstep;
         step(acc);
         if (acc) begin
            if (k == 0) acc0 = n; else acc1 = n;
            k++;
         end
         g++;
      end
      in_valid = 1'b0;
      chk("tp_accepts", k, 32'd2);
      chk("tp_interval", acc1 - acc0, 32'd6);
      g = 0;
      while (sb.size() > 0 && g < 40) begin step(acc); g++; end
      chk("tp_drained", sb.size(), 32'd0);

      // Degenerate WIDTH == CHUNK
      b_a = 8'h80; b_b = 8'h80; b_cin = 1'b0; b_in_valid = 1'b1;
      chk("w8_in_ready", {31'd0, b_in_ready}, 32'd1);
      sbb.push_back({1'b0, b_a} + {1'b0, b_b} + {8'd0, b_cin});
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      chk("w8_ov_not_yet", {31'd0, b_out_valid}, 32'd0);
      @(posedge clk); #1;
      chk("w8_latency_ov", {31'd0, b_out_valid}, 32'd1);
      eb = sbb.pop_front();
      chk("w8_sum", {24'd0, b_sum}, {24'd0, eb[7:0]});
      chk("w8_cout", {31'd0, b_cout}, {31'd0, eb[8]});
      @(posedge clk); #1;
      chk("w8_ov_drop", {31'd0, b_out_valid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end
endmodule
